// File: rtl/ts_multi_stream_arbiter_pkg.sv
// ts_multi_stream_arbiter_pkg: shared TS framing constants and arbiter state codes
package ts_multi_stream_arbiter_pkg;
  localparam int TS_PKT_LEN = 188;
  localparam logic [7:0] PKT_LEN8 = 8'(TS_PKT_LEN);
  localparam logic [7:0] LAST_BYTE = 8'(TS_PKT_LEN - 1);
  typedef enum logic [1:0] {IDLE, PRIME, SEND} arb_state_t;
endpackage

// File: rtl/ts_multi_stream_arbiter_packet_buffer.sv
// ts_multi_stream_arbiter_packet_buffer: one channel's ring of whole TS packets with drop accounting
module ts_multi_stream_arbiter_packet_buffer
  import ts_multi_stream_arbiter_pkg::*;
#(
  parameter int DEPTH_PKTS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data,
  input  logic        dvalid,
  input  logic        psync,
  input  logic        ena,
  input  logic        rd_req,
  input  logic        rel,
  output logic [7:0]  rd_data,
  output logic        pending,
  output logic [15:0] drop_cnt
);
  localparam int RAM_SIZE = DEPTH_PKTS * TS_PKT_LEN;
  localparam int AW = $clog2(RAM_SIZE);
  localparam int PW = $clog2(DEPTH_PKTS + 1);
  logic [7:0] ram [RAM_SIZE];
  logic [AW-1:0] wr_ptr, commit_ptr, rd_ptr, wr_addr;
  logic [PW-1:0] pkt_count;
  logic [7:0] byte_cnt;
  logic open, long_seen, short, start, no_space, long_hit, wr_en, commit, space;
  logic [1:0] drops;
  logic [16:0] drop_sum;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(RAM_SIZE - 1)) ? '0 : p + AW'(1);
  endfunction
  // Whole-packet slots: one free slot is exactly 188 free bytes
  always_comb begin
    space = pkt_count < PW'(DEPTH_PKTS);
    short = dvalid && psync && open && byte_cnt != PKT_LEN8;
    start = dvalid && psync && ena && space;
    no_space = dvalid && psync && ena && !space;
    long_hit = dvalid && !psync && open && byte_cnt == PKT_LEN8 && !long_seen;
    wr_en = start || (dvalid && !psync && open && byte_cnt != PKT_LEN8);
    wr_addr = psync ? commit_ptr : wr_ptr;
    commit = wr_en && !psync && byte_cnt == LAST_BYTE;
    drops = 2'(short) + 2'(no_space) + 2'(long_hit);
    drop_sum = {1'b0, drop_cnt} + 17'(drops);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      pkt_count <= '0;
      byte_cnt <= '0;
      open <= 1'b0;
      long_seen <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (dvalid && psync) begin
        open <= start;
        long_seen <= 1'b0;
        byte_cnt <= start ? 8'd1 : 8'd0;
        wr_ptr <= start ? nxt(commit_ptr) : commit_ptr;
      end else if (wr_en) begin
        wr_ptr <= nxt(wr_ptr);
        byte_cnt <= byte_cnt + 8'd1;
        if (commit) commit_ptr <= nxt(wr_ptr);
      end else if (long_hit) begin
        long_seen <= 1'b1;
      end
      if (rd_req) rd_ptr <= nxt(rd_ptr);
      pkt_count <= pkt_count + PW'(commit) - PW'(rel);
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= data;
    if (rd_req) rd_data <= ram[rd_ptr];
  end
  assign pending = pkt_count != '0;
endmodule

// File: rtl/ts_multi_stream_arbiter.sv
// ts_multi_stream_arbiter: per-channel whole-packet TS buffering with round-robin burst merge
module ts_multi_stream_arbiter
  import ts_multi_stream_arbiter_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int DEPTH_PKTS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_CH-1:0]  ts_data,
  input  logic [N_CH-1:0]    ts_dvalid,
  input  logic [N_CH-1:0]    ts_psync,
  input  logic [N_CH-1:0]    ch_ena,
  input  logic               ready,
  output logic [7:0]         merged_data,
  output logic               merged_dvalid,
  output logic               merged_psync,
  output logic [CH_W-1:0]    merged_ch,
  output logic [N_CH-1:0]    pkt_pending,
  output logic [16*N_CH-1:0] drop_cnt
);
  arb_state_t state, state_nx;
  logic [7:0] cnt;
  logic [CH_W-1:0] grant, rr_ptr, pick, idx;
  logic found, last;
  logic [N_CH-1:0] rd_req, rel;
  logic [7:0] rd_data [N_CH];
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    ts_multi_stream_arbiter_packet_buffer #(.DEPTH_PKTS(DEPTH_PKTS)) u_buf (
      .clk(clk),
      .rst(rst),
      .data(ts_data[8*k+:8]),
      .dvalid(ts_dvalid[k]),
      .psync(ts_psync[k]),
      .ena(ch_ena[k]),
      .rd_req(rd_req[k]),
      .rel(rel[k]),
      .rd_data(rd_data[k]),
      .pending(pkt_pending[k]),
      .drop_cnt(drop_cnt[16*k+:16])
    );
    assign rd_req[k] = grant == CH_W'(k) && (state == PRIME || (state == SEND && !last));
    assign rel[k] = grant == CH_W'(k) && state == SEND && last;
  end
  // Scan from rr_ptr+N_CH down to rr_ptr+1 so the nearest pending channel wins
  always_comb begin
    found = 1'b0;
    pick = rr_ptr;
    idx = rr_ptr;
    for (int i = N_CH; i >= 1; i--) begin
      idx = CH_W'((int'(rr_ptr) + i) % N_CH);
      if (pkt_pending[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
    last = cnt == LAST_BYTE;
    state_nx = state == IDLE ? ((ready && found) ? PRIME : IDLE)
             : state == PRIME ? SEND
             : last ? IDLE : SEND;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      grant <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nx;
      cnt <= (state == SEND && !last) ? cnt + 8'd1 : 8'd0;
      if (state == IDLE && ready && found) grant <= pick;
      if (|rel) rr_ptr <= grant;
    end
  end
  assign merged_dvalid = state == SEND;
  assign merged_psync = merged_dvalid && cnt == 8'd0;
  assign merged_data = merged_dvalid ? rd_data[grant] : 8'h00;
  assign merged_ch = grant;
endmodule
